// File: rtl/cmsdk_mcu_altfunc_seq_if.sv
// rtl/cmsdk_mcu_altfunc_seq_if.sv - configuration request handshake for the altfunc sequencer
interface cmsdk_mcu_altfunc_seq_if;
    logic        cfg_valid;
    logic [15:0] cfg_altfunc;
    logic        cfg_ready;
    logic        cfg_done;

    modport master (
        output cfg_valid,
        output cfg_altfunc,
        input  cfg_ready,
        input  cfg_done
    );

    modport slave (
        input  cfg_valid,
        input  cfg_altfunc,
        output cfg_ready,
        output cfg_done
    );
endinterface

// File: rtl/cmsdk_mcu_altfunc_seq.sv
// rtl/cmsdk_mcu_altfunc_seq.sv - glitch-free Port 1 alternate-function switch sequencer
module cmsdk_mcu_altfunc_seq #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] ALTFUNC_MASK  = 16'h002A
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    cmsdk_mcu_altfunc_seq_if.slave          cfg,
    input  logic [15:0]                     p1_outen_in,
    output logic [15:0]                     p1_outen_out,
    output logic [15:0]                     p1_altfunc,
    output logic                            busy
);

    // A zero setting still needs one blanking cycle ahead of the mux switch.
    localparam int         N_EFF    = (SETTLE_CYCLES < 1)   ? 1 :
                                      (SETTLE_CYCLES > 255) ? 255 : SETTLE_CYCLES;
    localparam logic [7:0] CNT_LOAD = 8'(N_EFF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SWITCH  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [15:0] alt_q,    alt_d;
    logic [15:0] target_q, target_d;
    logic [15:0] blank_q,  blank_d;
    logic        done_q,   done_d;

    logic        ready_w;
    logic        handshake_w;
    logic [15:0] req_target_w;
    logic [15:0] req_chg_w;

    assign ready_w      = (state_q == IDLE) && !HRESET;
    assign handshake_w  = cfg.cfg_valid && ready_w;
    assign req_target_w = cfg.cfg_altfunc & ALTFUNC_MASK;
    assign req_chg_w    = req_target_w ^ alt_q;

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            alt_q    <= 16'h0000;
            target_q <= 16'h0000;
            blank_q  <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alt_q    <= alt_d;
            target_q <= target_d;
            blank_q  <= blank_d;
            done_q   <= done_d;
        end
    end

    // Next state: blank changed pins, wait N cycles, switch mux, hold blank one more cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alt_d    = alt_q;
        target_d = target_q;
        blank_d  = blank_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake_w) begin
                    target_d = req_target_w;
                    if (req_chg_w != 16'h0000) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_LOAD;
                        blank_d = req_chg_w;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = SWITCH;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            SWITCH: begin
                alt_d   = target_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
                blank_d = 16'h0000;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                blank_d = 16'h0000;
            end
        endcase
    end

    // Outputs: pad enables gated by the registered blank mask only.
    always_comb begin
        cfg.cfg_ready = ready_w;
        cfg.cfg_done  = done_q;
        busy          = (state_q != IDLE);
        p1_outen_out  = p1_outen_in & ~blank_q;
        p1_altfunc    = alt_q & ALTFUNC_MASK;
    end

endmodule

// File: tb/tb_cmsdk_mcu_altfunc_seq.sv
// tb/tb_cmsdk_mcu_altfunc_seq.sv - self-checking bench for the altfunc sequencer
module tb_cmsdk_mcu_altfunc_seq;

    localparam int N = 4;

    typedef struct {
        logic [15:0] req;
        logic [15:0] outen;
        logic [15:0] exp_alt;
        logic [15:0] exp_blank;
        int          exp_lat;
    } vec_t;

    logic        HCLK;
    logic        HRESET;
    logic [15:0] p1_outen_in;
    logic [15:0] p1_outen_out;
    logic [15:0] p1_altfunc;
    logic        busy;

    cmsdk_mcu_altfunc_seq_if cfg_if ();

    cmsdk_mcu_altfunc_seq #(
        .SETTLE_CYCLES (N),
        .ALTFUNC_MASK  (16'h002A)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .cfg          (cfg_if),
        .p1_outen_in  (p1_outen_in),
        .p1_outen_out (p1_outen_out),
        .p1_altfunc   (p1_altfunc),
        .busy         (busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] model_alt;
    vec_t        sb[$];
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_altfunc = 16'hFFFF;
        p1_outen_in = 16'hA5A5;
        tick();
        tick();
        #1;
        chk("rst_ready", {15'd0, cfg_if.cfg_ready}, 16'd0);
        chk("rst_altfunc", p1_altfunc, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, cfg_if.cfg_done}, 16'd0);
        chk("rst_outen", p1_outen_out, 16'hA5A5);
        HRESET = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        #1;
        chk("ready_after_rst", {15'd0, cfg_if.cfg_ready}, 16'd1);
        model_alt = 16'h0000;
    endtask

    // Handshake in the current cycle, then follow the sequence to cfg_done.
    task automatic run_vec(input vec_t v, input bit inject, input bit rst_in_switch);
        logic [15:0] old_alt;
        vec_t        e;
        bit          finished;
        old_alt  = model_alt;
        finished = 1'b0;
        cfg_if.cfg_altfunc = v.req;
        cfg_if.cfg_valid   = 1'b1;
        p1_outen_in        = v.outen;
        #1;
        chk("ready_at_T", {15'd0, cfg_if.cfg_ready}, 16'd1);
        chk("done_single_cycle", {15'd0, cfg_if.cfg_done}, 16'd0);
        sb.push_back(v);
        tick();
        for (int k = 1; k <= 40 && !finished; k++) begin
            if (inject && k <= 3) begin
                cfg_if.cfg_valid   = 1'b1;
                cfg_if.cfg_altfunc = 16'h0020;
            end else begin
                cfg_if.cfg_valid   = 1'b0;
                cfg_if.cfg_altfunc = 16'($urandom);
            end
            if (rst_in_switch && k == N + 1) HRESET = 1'b1;
            #1;
            if (cfg_if.cfg_done) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 16'd1, 16'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 16'(k), 16'(e.exp_lat));
                    chk("final_altfunc", p1_altfunc, e.exp_alt);
                    chk("outen_released", p1_outen_out, e.outen);
                    chk("busy_at_done", {15'd0, busy}, 16'd0);
                    model_alt = e.exp_alt;
                end
                finished = 1'b1;
            end else begin
                chk("busy", {15'd0, busy}, {15'd0, v.exp_blank != 16'h0000});
                chk("outen_blanked", p1_outen_out, v.outen & ~v.exp_blank);
                chk("altfunc_timing", p1_altfunc, (k >= N + 2) ? v.exp_alt : old_alt);
                if (rst_in_switch && k == N + 1) begin
                    tick();
                    HRESET = 1'b0;
                    #1;
                    chk("abort_altfunc", p1_altfunc, 16'h0000);
                    chk("abort_busy", {15'd0, busy}, 16'd0);
                    chk("abort_outen", p1_outen_out, v.outen);
                    chk("abort_ready", {15'd0, cfg_if.cfg_ready}, 16'd1);
                    void'(sb.pop_front());
                    model_alt = 16'h0000;
                    for (int j = 0; j < 10; j++) begin
                        chk("abort_no_done", {15'd0, cfg_if.cfg_done}, 16'd0);
                        tick();
                    end
                    finished = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        if (!finished) chk("timeout_cfg_done", 16'd1, 16'd0);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        HRESET             = 1'b1;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_altfunc = 16'h0000;
        p1_outen_in        = 16'hFFFF;
        model_alt          = 16'h0000;

        //          req       outen     exp_alt   exp_blank lat
        tbl[0] = '{16'hFFFF, 16'hFFFF, 16'h002A, 16'h002A, N + 3};
        tbl[1] = '{16'h0002, 16'hFFFF, 16'h0002, 16'h0028, N + 3};
        tbl[2] = '{16'h0002, 16'hFFFF, 16'h0002, 16'h0000, 1};
        tbl[3] = '{16'h0008, 16'h0F0F, 16'h0008, 16'h000A, N + 3};
        tbl[4] = '{16'h0008, 16'hFFFF, 16'h0008, 16'h0000, 1};
        tbl[5] = '{16'h0000, 16'h1234, 16'h0000, 16'h0008, N + 3};
        tbl[6] = '{16'hFFD5, 16'hFFFF, 16'h0000, 16'h0000, 1};
        tbl[7] = '{16'h0002, 16'hFFFF, 16'h0002, 16'h0002, N + 3};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], 1'b0, 1'b0);
            tick();
        end

        // Requests during SETTLE are dropped; the in-flight one completes unchanged.
        run_vec('{16'h0000, 16'hFFFF, 16'h0000, 16'h0002, N + 3}, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("ignored_req_not_applied", p1_altfunc, 16'h0000);
            chk("ignored_req_idle", {15'd0, busy}, 16'd0);
        end

        // Reset during SWITCH after an earlier change to 000A.
        run_vec('{16'h000A, 16'hFFFF, 16'h000A, 16'h000A, N + 3}, 1'b0, 1'b0);
        tick();
        run_vec('{16'h0002, 16'hFFFF, 16'h0002, 16'h0008, N + 3}, 1'b0, 1'b1);

        // Back-to-back: second request issued the cycle after cfg_done.
        run_vec('{16'h0002, 16'hFFFF, 16'h0002, 16'h0002, N + 3}, 1'b0, 1'b0);
        tick();
        run_vec('{16'h0022, 16'hFFFF, 16'h0022, 16'h0020, N + 3}, 1'b0, 1'b0);
        chk("b2b_final", p1_altfunc, 16'h0022);

        if (sb.size() != 0) chk("sb_leftover", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
